br_puf_ctrl: RTL and testbench
==============================

BR_PUF_CTRL -- requirements
Module: br_puf_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64: challenge/ring stage count, 8..256.
REQ-002 SHALL have parameter RESET_CYCLES, default 8: ring-reset pulse length in cycles, >=1.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 32: release-to-sample wait in cycles, >=2.
REQ-004 SHALL have parameter REPS_W, default 4: repetition-count width.
REQ-005 SHALL have port CLK, input, 1: sole clock.
REQ-006 SHALL have port RESET, input, 1: one clock; reset is synchronous and active-high.
REQ-007 SHALL have port REQ_VALID, input, 1: evaluation request.
REQ-008 SHALL have port REQ_READY, output, 1: request accepted when REQ_VALID and REQ_READY are both high.
REQ-009 SHALL have port CHAL, input, WIDTH: challenge, sampled on accept.
REQ-010 SHALL have port NREP, input, REPS_W: number of evaluations, sampled on accept.
REQ-011 SHALL have port RSP_VALID, output, 1: response available.
REQ-012 SHALL have port RSP_READY, input, 1: response consumed when RSP_VALID and RSP_READY are both high.
REQ-013 SHALL have port RSP_BIT, output, 1: majority-voted response.
REQ-014 SHALL have port RSP_ONES, output, REPS_W+1: count of samples that were 1.
REQ-015 SHALL have port RING_RESET, output, 1: drives the ring macro RESET.
REQ-016 SHALL have port RING_C, output, WIDTH: drives the ring macro challenge.
REQ-017 SHALL have port RING_OUT, input, 1: ring output, asynchronous to CLK.

Function
REQ-018 SHALL use FSM states IDLE, RST, SETTLE, SAMPLE, RESP.
REQ-019 SHALL transition IDLE->RST on accept; CHAL is latched into RING_C, and NREP is latched with 0 treated as 1.
REQ-020 SHALL hold RST for exactly RESET_CYCLES cycles, then go to SETTLE.
REQ-021 SHALL hold SETTLE for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-022 SHALL hold SAMPLE for 1 cycle: capture synchronised RING_OUT; increment the ones count if 1; increment the rep count.
REQ-023 SHALL go SAMPLE->RST if reps done < NREP, else SAMPLE->RESP.
REQ-024 SHALL pass RING_OUT through a 2-flop synchroniser before use.
REQ-025 SHALL drive RING_RESET=1 in IDLE, RST and RESP, and RING_RESET=0 in SETTLE and SAMPLE.
REQ-026 SHALL hold RING_C constant from accept until the end of RESP.
REQ-027 SHALL drive REQ_READY=1 only in IDLE and RSP_VALID=1 only in RESP.
REQ-028 SHALL set RSP_BIT=1 iff 2*ones > NREP, so a tie gives 0.
REQ-029 SHALL register RSP_BIT and RSP_ONES, holding them stable throughout RESP.
REQ-030 SHALL assert RSP_VALID exactly NREP*(RESET_CYCLES+SETTLE_CYCLES+1) cycles after the accept edge.
REQ-031 SHALL keep RESP, and outputs stable, until RSP_READY=1, then go to IDLE; no new request is accepted in that same cycle.
REQ-032 SHALL never compute the ones count beyond 2^REPS_W-1, so RSP_ONES is not truncated.

Reset
REQ-033 SHALL, while RESET=1 at a clock edge, force state=IDLE and clear the counters, RING_C=0, RSP_BIT=0 and RSP_ONES=0.
REQ-034 SHALL give reset values REQ_READY=1, RSP_VALID=0, RING_RESET=1 and RING_C=0; REQ_VALID is ignored during RESET.
REQ-035 SHALL, on RESET mid-evaluation (any state), abort the evaluation and discard any partial count.

Structure
REQ-036 SHALL place the state enum and the parameter defaults in shared package br_puf_pkg.
REQ-037 SHALL implement the synchroniser as sub-module br_sync2.
REQ-038 SHALL instantiate no ring model in this block; the bench provides a behavioural ring.

Verification (WIDTH=8, RESET_CYCLES=2, SETTLE_CYCLES=4)
REQ-039 SHALL cover: NREP=1, CHAL=8'hA5, ring=1 -> RSP_VALID 7 cycles after accept, RSP_BIT=1, RSP_ONES=1, RING_C=8'hA5.
REQ-040 SHALL cover: NREP=3, ring samples 1,0,1 -> RSP_VALID 21 cycles after accept, RSP_BIT=1, RSP_ONES=2.
REQ-041 SHALL cover: NREP=2, samples 1,0 -> RSP_BIT=0, RSP_ONES=1 (tie); and NREP=0 -> one evaluation, 7 cycles.
REQ-042 SHALL cover: RSP_READY low 5 cycles in RESP -> outputs stable, REQ_READY=0; REQ_READY=1 the cycle after the handshake.
REQ-043 SHALL cover: RESET pulsed in SETTLE of rep 2 -> next cycle IDLE, RING_RESET=1, RSP_VALID=0, REQ_READY=1, RSP_ONES=0.
REQ-044 SHALL cover: RING_RESET waveform per rep -> high 2 cycles, low 5 cycles, RING_C unchanged throughout.

Source files
------------

// File: rtl/br_puf_pkg.sv
// Shared definitions for the bistable-ring PUF controller: FSM states,
// parameter defaults and the majority-vote helper.
package br_puf_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RST    = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      RESP   = 3'd4
   } state_e;

   localparam int WIDTH_DEF         = 64;
   localparam int RESET_CYCLES_DEF  = 8;
   localparam int SETTLE_CYCLES_DEF = 32;
   localparam int REPS_W_DEF        = 4;

   // Strict majority: a tie resolves to 0.
   function automatic logic majority(input logic [31:0] ones, input logic [31:0] nrep);
      return ({ones[30:0], 1'b0} > nrep);
   endfunction

endpackage

// File: rtl/br_sync2.sv
// Two-flop synchroniser that brings the free-running ring output into the CLK domain.
module br_sync2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Metastability-settling register pair.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/br_puf_ctrl.sv
// Bistable-ring PUF evaluation controller: resets and releases the ring NREP
// times, samples the settled output each time and returns a majority vote.
module br_puf_ctrl
   import br_puf_pkg::*;
#(
   parameter int WIDTH         = WIDTH_DEF,
   parameter int RESET_CYCLES  = RESET_CYCLES_DEF,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int REPS_W        = REPS_W_DEF
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic [WIDTH-1:0]  CHAL,
   input  logic [REPS_W-1:0] NREP,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic              RSP_BIT,
   output logic [REPS_W:0]   RSP_ONES,
   output logic              RING_RESET,
   output logic [WIDTH-1:0]  RING_C,
   input  logic              RING_OUT
);

   localparam int CYC_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CYC_MAX + 1);
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cyc_q, cyc_d;
   logic [REPS_W-1:0]  rep_q, rep_d, rep_inc;
   logic [REPS_W-1:0]  nrep_q, nrep_d;
   logic [REPS_W:0]    ones_q, ones_d, ones_inc;
   logic [REPS_W:0]    rsp_ones_q, rsp_ones_d;
   logic [WIDTH-1:0]   chal_q, chal_d;
   logic               rsp_bit_q, rsp_bit_d;
   logic               req_ready_q, rsp_valid_q, ring_reset_q;
   logic               ring_sync;

   br_sync2 u_sync (
      .clk_i (CLK),
      .rst_i (RESET),
      .d_i   (RING_OUT),
      .q_o   (ring_sync)
   );

   // Next-state and datapath update for the evaluation sequence.
   always_comb begin
      rep_inc    = rep_q + REPS_W'(1);
      ones_inc   = ones_q + {{REPS_W{1'b0}}, ring_sync};
      state_d    = state_q;
      cyc_d      = cyc_q;
      rep_d      = rep_q;
      nrep_d     = nrep_q;
      ones_d     = ones_q;
      chal_d     = chal_q;
      rsp_bit_d  = rsp_bit_q;
      rsp_ones_d = rsp_ones_q;
      case (state_q)
         IDLE: begin
            if (REQ_VALID) begin
               state_d = RST;
               chal_d  = CHAL;
               nrep_d  = (NREP == '0) ? REPS_W'(1) : NREP;
               cyc_d   = '0;
               rep_d   = '0;
               ones_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RST: begin
            if (cyc_q == RST_LAST) begin
               state_d = SETTLE;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_q + CNT_W'(1);
            end
         end
         SETTLE: begin
            if (cyc_q == SETTLE_LAST) begin
               state_d = SAMPLE;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_q + CNT_W'(1);
            end
         end
         SAMPLE: begin
            ones_d = ones_inc;
            rep_d  = rep_inc;
            // rep_inc never exceeds nrep_q, so the count fits in REPS_W+1 bits.
            if (rep_inc < nrep_q) begin
               state_d = RST;
            end else begin
               state_d    = RESP;
               rsp_ones_d = ones_inc;
               rsp_bit_d  = majority(32'(ones_inc), 32'(nrep_q));
            end
         end
         RESP: begin
            if (RSP_READY) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake/ring-control outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= IDLE;
         cyc_q        <= '0;
         rep_q        <= '0;
         nrep_q       <= '0;
         ones_q       <= '0;
         chal_q       <= '0;
         rsp_bit_q    <= 1'b0;
         rsp_ones_q   <= '0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         ring_reset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         rep_q        <= rep_d;
         nrep_q       <= nrep_d;
         ones_q       <= ones_d;
         chal_q       <= chal_d;
         rsp_bit_q    <= rsp_bit_d;
         rsp_ones_q   <= rsp_ones_d;
         req_ready_q  <= (state_d == IDLE);
         rsp_valid_q  <= (state_d == RESP);
         ring_reset_q <= (state_d == IDLE) || (state_d == RST) || (state_d == RESP);
      end
   end

   assign REQ_READY  = req_ready_q;
   assign RSP_VALID  = rsp_valid_q;
   assign RSP_BIT    = rsp_bit_q;
   assign RSP_ONES   = rsp_ones_q;
   assign RING_RESET = ring_reset_q;
   assign RING_C     = chal_q;

endmodule

// File: tb/tb_br_puf_ctrl.sv
// Self-checking bench for br_puf_ctrl with a behavioural bistable ring whose
// settled value per evaluation is scripted by each scenario.
module tb_br_puf_ctrl;

   localparam int WIDTH = 8;
   localparam int RC    = 2;
   localparam int SC    = 4;
   localparam int RW    = 4;
   localparam int PER   = RC + SC + 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [WIDTH-1:0] chal = '0;
   logic [RW-1:0]    nrep = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic             rsp_bit;
   logic [RW:0]      rsp_ones;
   logic             ring_reset;
   logic [WIDTH-1:0] ring_c;
   logic             ring_out;

   int checks = 0;
   int errors = 0;

   logic ring_q[$];
   logic ring_bit = 1'b0;

   always #5 clk = ~clk;

   br_puf_ctrl #(
      .WIDTH         (WIDTH),
      .RESET_CYCLES  (RC),
      .SETTLE_CYCLES (SC),
      .REPS_W        (RW)
   ) dut (
      .CLK        (clk),
      .RESET      (reset),
      .REQ_VALID  (req_valid),
      .REQ_READY  (req_ready),
      .CHAL       (chal),
      .NREP       (nrep),
      .RSP_VALID  (rsp_valid),
      .RSP_READY  (rsp_ready),
      .RSP_BIT    (rsp_bit),
      .RSP_ONES   (rsp_ones),
      .RING_RESET (ring_reset),
      .RING_C     (ring_c),
      .RING_OUT   (ring_out)
   );

   // Behavioural ring: held at 0 while reset, settles to the next scripted value on release.
   always @(negedge ring_reset) begin
      if (ring_q.size() > 0) ring_bit = ring_q.pop_front();
      else ring_bit = 1'b0;
   end
   assign ring_out = ring_reset ? 1'b0 : ring_bit;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic run_eval(input string name, input logic [WIDTH-1:0] c, input int n_in,
                           input logic [15:0] bits, input int hold);
      int          n, ones, j;
      bit          timed_out;
      logic        exp_bit;
      logic [RW:0] exp_ones;
      n = (n_in == 0) ? 1 : n_in;
      ring_q.delete();
      ones = 0;
      for (int i = 0; i < n; i++) begin
         ring_q.push_back(bits[i]);
         ones += int'(bits[i]);
      end
      exp_bit  = (2 * ones > n);
      exp_ones = ones[RW:0];
      @(negedge clk);
      req_valid = 1'b1;
      chal      = c;
      nrep      = n_in[RW-1:0];
      @(posedge clk); #1;
      req_valid = 1'b0;
      chal      = ~c;
      j = 0;
      timed_out = 0;
      while (rsp_valid !== 1'b1 && !timed_out) begin
         checks += 3;
         if (ring_reset !== ((j % PER) < RC)) begin
            errors++;
            $display("FAIL %s ring_reset cycle %0d: got %b expected %b", name, j, ring_reset, ((j % PER) < RC));
         end
         if (ring_c !== c) begin
            errors++;
            $display("FAIL %s ring_c cycle %0d: got %h expected %h", name, j, ring_c, c);
         end
         if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s req_ready busy cycle %0d: got %b expected 0", name, j, req_ready);
         end
         if (j >= n * PER + 4) timed_out = 1;
         else begin
            @(posedge clk); #1;
            j++;
         end
      end
      checks++;
      if (timed_out || j != n * PER) begin
         errors++;
         $display("FAIL %s latency: got %0d expected %0d (timeout=%0d)", name, j, n * PER, timed_out);
      end
      if (!timed_out) begin
         for (int k = 0; k <= hold; k++) begin
            checks += 6;
            if (rsp_valid !== 1'b1) begin
               errors++;
               $display("FAIL %s rsp_valid hold %0d: got %b expected 1", name, k, rsp_valid);
            end
            if (rsp_bit !== exp_bit) begin
               errors++;
               $display("FAIL %s rsp_bit hold %0d: got %b expected %b", name, k, rsp_bit, exp_bit);
            end
            if (rsp_ones !== exp_ones) begin
               errors++;
               $display("FAIL %s rsp_ones hold %0d: got %0d expected %0d", name, k, rsp_ones, exp_ones);
            end
            if (req_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s req_ready in resp %0d: got %b expected 0", name, k, req_ready);
            end
            if (ring_reset !== 1'b1) begin
               errors++;
               $display("FAIL %s ring_reset in resp %0d: got %b expected 1", name, k, ring_reset);
            end
            if (ring_c !== c) begin
               errors++;
               $display("FAIL %s ring_c in resp %0d: got %h expected %h", name, k, ring_c, c);
            end
            if (k < hold) begin
               @(posedge clk); #1;
            end
         end
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         rsp_ready = 1'b0;
         checks += 2;
         if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s rsp_valid after handshake: got %b expected 0", name, rsp_valid);
         end
         if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready after handshake: got %b expected 1", name, req_ready);
         end
      end
   endtask

   task automatic test_reset;
      reset     = 1'b1;
      req_valid = 1'b1;
      chal      = 8'hFF;
      nrep      = 4'd3;
      repeat (3) @(posedge clk);
      #1;
      checks += 6;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %b expected 0", rsp_valid); end
      if (ring_reset !== 1'b1) begin errors++; $display("FAIL reset ring_reset: got %b expected 1", ring_reset); end
      if (ring_c !== 8'h00) begin errors++; $display("FAIL reset ring_c: got %h expected 00", ring_c); end
      if (rsp_ones !== 5'd0) begin errors++; $display("FAIL reset rsp_ones: got %0d expected 0", rsp_ones); end
      if (rsp_bit !== 1'b0) begin errors++; $display("FAIL reset rsp_bit: got %b expected 0", rsp_bit); end
      @(negedge clk);
      req_valid = 1'b0;
      reset     = 1'b0;
      @(posedge clk); #1;
      checks += 2;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL post-reset req_ready: got %b expected 1", req_ready); end
      if (ring_reset !== 1'b1) begin errors++; $display("FAIL post-reset ring_reset: got %b expected 1", ring_reset); end
   endtask

   task automatic test_single;
      run_eval("single", 8'hA5, 1, 16'h0001, 0);
   endtask

   task automatic test_majority;
      run_eval("maj3", 8'h3C, 3, 16'b101, 0);
      run_eval("tie2", 8'h11, 2, 16'b01, 0);
      run_eval("nrep0", 8'h7E, 0, 16'h0001, 0);
   endtask

   task automatic test_hold;
      run_eval("hold5", 8'hC3, 2, 16'b11, 5);
   endtask

   task automatic test_max;
      run_eval("max15", 8'h96, 15, 16'h7FFF, 1);
   endtask

   task automatic test_reset_mid;
      ring_q.delete();
      for (int i = 0; i < 3; i++) ring_q.push_back(1'b1);
      @(negedge clk);
      req_valid = 1'b1;
      chal      = 8'h3C;
      nrep      = 4'd3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (PER + 3) begin
         @(posedge clk); #1;
      end
      checks++;
      if (ring_reset !== 1'b0) begin errors++; $display("FAIL midreset scenario ring_reset: got %b expected 0", ring_reset); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks += 5;
      if (ring_reset !== 1'b1) begin errors++; $display("FAIL midreset ring_reset: got %b expected 1", ring_reset); end
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset rsp_valid: got %b expected 0", rsp_valid); end
      if (req_ready !== 1'b1) begin errors++; $display("FAIL midreset req_ready: got %b expected 1", req_ready); end
      if (rsp_ones !== 5'd0) begin errors++; $display("FAIL midreset rsp_ones: got %0d expected 0", rsp_ones); end
      if (ring_c !== 8'h00) begin errors++; $display("FAIL midreset ring_c: got %h expected 00", ring_c); end
      run_eval("post_midreset", 8'h5A, 1, 16'h0000, 0);
   endtask

   task automatic test_back_to_back;
      run_eval("b2b_a", 8'h01, 1, 16'h0000, 0);
      run_eval("b2b_b", 8'h80, 1, 16'h0001, 0);
   endtask

   task automatic test_random;
      for (int it = 0; it < 10; it++) begin
         run_eval("random", WIDTH'($urandom), int'($urandom_range(0, 6)),
                  16'($urandom), int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_majority();
      test_hold();
      test_max();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
